clock_period_meter: RTL

- Downstream consumer of the divided/selected clock output of the clock divide-and-select stage.
- Synchronises that slow clock into the system `clk` domain and measures its rising-to-rising period in `clk` cycles.
- Reports each measurement with a one-cycle valid strobe, plus a stability flag and an overflow flag.
- Drives the otherwise-unused upper output bits in the top-level wrapper.

---
 rtl/clock_period_meter_if.sv | 26 ++
 rtl/clock_period_meter.sv | 111 +++++++++++
 2 files changed

// File: rtl/clock_period_meter_if.sv
// Purpose : bundles the measured clock, enable and measurement results of clock_period_meter.
// Latency : n/a (signal bundle only).
// Backpressure: none; results are strobed with valid and must be taken that cycle.
// Ports   : meas_in/enable flow master->slave; period_out/valid/stable/overflow flow slave->master.
interface clock_period_meter_if #(
  parameter int CNT_W = 8
);
  logic             meas_in;
  logic             enable;
  logic [CNT_W-1:0] period_out;
  logic             valid;
  logic             stable;
  logic             overflow;

  // master: the agent that supplies the clock under test and consumes results
  modport master (
    output meas_in, enable,
    input  period_out, valid, stable, overflow
  );

  // slave: the meter itself
  modport slave (
    input  meas_in, enable,
    output period_out, valid, stable, overflow
  );
endinterface

// File: rtl/clock_period_meter.sv
// Purpose : measures the rising-to-rising period of meas_in in clk cycles, with stable/overflow flags.
// Latency : edge seen SYNC_STAGES+1 clk edges after meas_in rises; outputs registered on that edge.
// Backpressure: none; one-cycle valid strobe per report, consumer must sample it.
// Ports   : clk, reset (async, active-high); bus (slave modport): meas_in, enable in;
//           period_out[CNT_W], valid, stable, overflow out.
module clock_period_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input logic                  clk,
  input logic                  reset,
  clock_period_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   meas_edge;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             first;      // next edge-report is the first since ARM
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             stable_q;
  logic             overflow_q;

  // Synchroniser plus edge register. Latency is fixed, so it cancels out of
  // every rise-to-rise difference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.meas_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign meas_edge = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      first      <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable) begin
        // period_q and overflow_q deliberately hold their last values
        state    <= IDLE;
        counter  <= '0;
        stable_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= ARM;
          end
          ARM: begin
            // first edge only starts timing; nothing is reported
            if (meas_edge) begin
              counter <= CNT_ONE;
              first   <= 1'b1;
              state   <= COUNT;
            end
          end
          COUNT: begin
            if (meas_edge) begin
              // edge beats saturation when both land in the same cycle
              period_q   <= counter;
              valid_q    <= 1'b1;
              overflow_q <= 1'b0;
              stable_q   <= !first && !overflow_q && (counter == period_q);
              first      <= 1'b0;
              counter    <= CNT_ONE;
            end else if (counter == CNT_MAX) begin
              period_q   <= CNT_MAX;
              valid_q    <= 1'b1;
              overflow_q <= 1'b1;
              stable_q   <= 1'b0;
              counter    <= '0;
              state      <= ARM;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.stable     = stable_q;
  assign bus.overflow   = overflow_q;

endmodule
